// File: rtl/dsp48a1_pkg.sv
// dsp48a1_pkg: shared widths, OPMODE bit positions and the X/Z mux encodings
// used by the dsp48a1 multiply-accumulate slice.
package dsp48a1_pkg;

   localparam int OPMODE_WIDTH = 8;
   localparam int A_DATA_WIDTH = 18;
   localparam int B_DATA_WIDTH = 18;
   localparam int D_DATA_WIDTH = 18;
   localparam int C_DATA_WIDTH = 48;
   localparam int P_DATA_WIDTH = 48;
   localparam int M_DATA_WIDTH = 36;

   // Low D bits that fill the top of the {D,A,B} X-mux operand.
   localparam int X_CONCAT_D_BITS = P_DATA_WIDTH - A_DATA_WIDTH - B_DATA_WIDTH;

   localparam int OP_X_LSB      = 0;
   localparam int OP_Z_LSB      = 2;
   localparam int OP_PREADD_SEL = 4;
   localparam int OP_CARRYIN    = 5;
   localparam int OP_PRE_SUB    = 6;
   localparam int OP_POST_SUB   = 7;

   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_M    = 2'b01,
      X_P    = 2'b10,
      X_DAB  = 2'b11
   } x_sel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'b00,
      Z_PCIN = 2'b01,
      Z_P    = 2'b10,
      Z_C    = 2'b11
   } z_sel_e;

   // 49-bit post-adder; on subtract the carry bit is the borrow out.
   function automatic logic [P_DATA_WIDTH:0] post_add(
      input logic [P_DATA_WIDTH-1:0] z,
      input logic [P_DATA_WIDTH-1:0] x,
      input logic                    cin,
      input logic                    sub
   );
      logic [P_DATA_WIDTH:0] z_ext;
      logic [P_DATA_WIDTH:0] x_ext;
      logic [P_DATA_WIDTH:0] c_ext;
      z_ext = {1'b0, z};
      x_ext = {1'b0, x};
      c_ext = {{P_DATA_WIDTH{1'b0}}, cin};
      return sub ? (z_ext - (x_ext + c_ext)) : (z_ext + x_ext + c_ext);
   endfunction

endpackage

// File: rtl/dsp48a1_pipe_reg.sv
// dsp48a1_pipe_reg: one optional pipeline stage of the slice; a clock-enabled
// register with async reset, or a straight wire when REGISTERED is 0.
module dsp48a1_pipe_reg #(
   parameter int WIDTH      = 18,
   parameter int REGISTERED = 1
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (REGISTERED == 1) begin : g_reg
         // NOTE: non-blocking assignment keeps every stage sampling pre-edge values.
         always_ff @(posedge CLK or posedge rst) begin
            if (rst) begin
               q <= '0;
            end else if (ce) begin
               q <= d;
            end
         end
      end else begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = ^{CLK, rst, ce};
         assign q = d;
      end
   endgenerate

endmodule

// File: rtl/dsp48a1.sv
// dsp48a1: Spartan-6 style MAC slice (pre-adder, 18x18 multiply, 48-bit post-adder).
// The pre-adder is built only when DSP48A1_PREADDER_EN is defined.
module dsp48a1
   import dsp48a1_pkg::*;
#(
   parameter int    A0REG       = 0,
   parameter int    A1REG       = 1,
   parameter int    B0REG       = 0,
   parameter int    B1REG       = 1,
   parameter int    CREG        = 1,
   parameter int    DREG        = 1,
   parameter int    MREG        = 1,
   parameter int    PREG        = 1,
   parameter int    CARRYINREG  = 1,
   parameter int    CARRYOUTREG = 1,
   parameter int    OPMODEREG   = 1,
   parameter string CARRYINSEL  = "OPMODE5",
   parameter string B_INPUT     = "DIRECT"
) (
   input  logic                    CLK,
   input  logic                    RSTA,
   input  logic                    RSTB,
   input  logic                    RSTC,
   input  logic                    RSTD,
   input  logic                    RSTM,
   input  logic                    RSTP,
   input  logic                    RSTCARRYIN,
   input  logic                    RSTOPMODE,
   input  logic                    CEA,
   input  logic                    CEB,
   input  logic                    CEC,
   input  logic                    CED,
   input  logic                    CEM,
   input  logic                    CEP,
   input  logic                    CEOPMODE,
   input  logic                    CECARRYIN,
   input  logic [A_DATA_WIDTH-1:0] A,
   input  logic [B_DATA_WIDTH-1:0] B,
   input  logic [D_DATA_WIDTH-1:0] D,
   input  logic [C_DATA_WIDTH-1:0] C,
   input  logic [B_DATA_WIDTH-1:0] BCIN,
   input  logic [P_DATA_WIDTH-1:0] PCIN,
   input  logic                    CARRYIN,
   input  logic [OPMODE_WIDTH-1:0] OPMODE,
   output logic [B_DATA_WIDTH-1:0] BCOUT,
   output logic [M_DATA_WIDTH-1:0] M,
   output logic [P_DATA_WIDTH-1:0] P,
   output logic [P_DATA_WIDTH-1:0] PCOUT,
   output logic                    CARRYOUT,
   output logic                    CARRYOUTF
);

   logic [A_DATA_WIDTH-1:0] a0_q;
   logic [A_DATA_WIDTH-1:0] a1_q;
   logic [B_DATA_WIDTH-1:0] b_src;
   logic [B_DATA_WIDTH-1:0] b0_q;
   logic [B_DATA_WIDTH-1:0] b1_d;
   logic [B_DATA_WIDTH-1:0] b1_q;
   logic [D_DATA_WIDTH-1:0] d_q;
   logic [C_DATA_WIDTH-1:0] c_q;
   logic [OPMODE_WIDTH-1:0] opmode_q;
   logic [M_DATA_WIDTH-1:0] m_d;
   logic [M_DATA_WIDTH-1:0] m_q;
   logic [P_DATA_WIDTH-1:0] x_mux;
   logic [P_DATA_WIDTH-1:0] z_mux;
   logic [P_DATA_WIDTH-1:0] p_q;
   logic [P_DATA_WIDTH:0]   post_sum;
   logic                    cin_d;
   logic                    cin_q;
   logic                    cout_q;

   assign b_src = (B_INPUT == "CASCADED") ? BCIN : B;

   dsp48a1_pipe_reg #(.WIDTH(A_DATA_WIDTH), .REGISTERED(A0REG)) u_a0 (
      .CLK(CLK), .rst(RSTA), .ce(CEA), .d(A), .q(a0_q));
   dsp48a1_pipe_reg #(.WIDTH(A_DATA_WIDTH), .REGISTERED(A1REG)) u_a1 (
      .CLK(CLK), .rst(RSTA), .ce(CEA), .d(a0_q), .q(a1_q));
   dsp48a1_pipe_reg #(.WIDTH(B_DATA_WIDTH), .REGISTERED(B0REG)) u_b0 (
      .CLK(CLK), .rst(RSTB), .ce(CEB), .d(b_src), .q(b0_q));
   dsp48a1_pipe_reg #(.WIDTH(D_DATA_WIDTH), .REGISTERED(DREG)) u_d (
      .CLK(CLK), .rst(RSTD), .ce(CED), .d(D), .q(d_q));
   dsp48a1_pipe_reg #(.WIDTH(C_DATA_WIDTH), .REGISTERED(CREG)) u_c (
      .CLK(CLK), .rst(RSTC), .ce(CEC), .d(C), .q(c_q));
   dsp48a1_pipe_reg #(.WIDTH(OPMODE_WIDTH), .REGISTERED(OPMODEREG)) u_opmode (
      .CLK(CLK), .rst(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(opmode_q));

`ifdef DSP48A1_PREADDER_EN
   logic [B_DATA_WIDTH-1:0] pre_sum;
   assign pre_sum = opmode_q[OP_PRE_SUB] ? (d_q - b0_q) : (d_q + b0_q);
   assign b1_d    = opmode_q[OP_PREADD_SEL] ? pre_sum : b0_q;
`else
   // Without the pre-adder only the low D bits (X-mux concat) are consumed.
   logic unused_preadd;
   assign unused_preadd = ^{d_q[D_DATA_WIDTH-1:X_CONCAT_D_BITS],
                            opmode_q[OP_PRE_SUB], opmode_q[OP_PREADD_SEL]};
   assign b1_d = b0_q;
`endif

   dsp48a1_pipe_reg #(.WIDTH(B_DATA_WIDTH), .REGISTERED(B1REG)) u_b1 (
      .CLK(CLK), .rst(RSTB), .ce(CEB), .d(b1_d), .q(b1_q));

   assign m_d = M_DATA_WIDTH'(a1_q) * M_DATA_WIDTH'(b1_q);

   dsp48a1_pipe_reg #(.WIDTH(M_DATA_WIDTH), .REGISTERED(MREG)) u_m (
      .CLK(CLK), .rst(RSTM), .ce(CEM), .d(m_d), .q(m_q));

   assign cin_d = (CARRYINSEL == "CARRYIN") ? CARRYIN : opmode_q[OP_CARRYIN];

   dsp48a1_pipe_reg #(.WIDTH(1), .REGISTERED(CARRYINREG)) u_cin (
      .CLK(CLK), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cin_d), .q(cin_q));

   always_comb begin
      // NOTE: default assignment first so no select value can infer a latch.
      x_mux = '0;
      case (x_sel_e'(opmode_q[OP_X_LSB +: 2]))
         X_M:     x_mux = {{(P_DATA_WIDTH - M_DATA_WIDTH){1'b0}}, m_q};
         X_P:     x_mux = p_q;
         X_DAB:   x_mux = {d_q[X_CONCAT_D_BITS-1:0], a1_q, b1_q};
         default: x_mux = '0;
      endcase
   end

   always_comb begin
      z_mux = '0;
      case (z_sel_e'(opmode_q[OP_Z_LSB +: 2]))
         Z_PCIN:  z_mux = PCIN;
         Z_P:     z_mux = p_q;
         Z_C:     z_mux = c_q;
         default: z_mux = '0;
      endcase
   end

   // Feedback through p_q gives accumulation against the pre-edge P.
   assign post_sum = post_add(z_mux, x_mux, cin_q, opmode_q[OP_POST_SUB]);

   dsp48a1_pipe_reg #(.WIDTH(P_DATA_WIDTH), .REGISTERED(PREG)) u_p (
      .CLK(CLK), .rst(RSTP), .ce(CEP), .d(post_sum[P_DATA_WIDTH-1:0]), .q(p_q));
   dsp48a1_pipe_reg #(.WIDTH(1), .REGISTERED(CARRYOUTREG)) u_cout (
      .CLK(CLK), .rst(RSTCARRYIN), .ce(CECARRYIN), .d(post_sum[P_DATA_WIDTH]), .q(cout_q));

   assign BCOUT     = b1_q;
   assign M         = m_q;
   assign P         = p_q;
   assign PCOUT     = p_q;
   assign CARRYOUT  = cout_q;
   assign CARRYOUTF = cout_q;

endmodule

// File: tb/tb_dsp48a1.sv
// tb_dsp48a1: directed self-checking bench for the dsp48a1 MAC slice in its
// default pipeline configuration, plus a CARRYIN-sourced instance for accumulation.
module tb_dsp48a1;

`ifdef DSP48A1_PREADDER_EN
   localparam bit PREADD = 1'b1;
`else
   localparam bit PREADD = 1'b0;
`endif

   logic        CLK;
   logic        rsta, rstb, rstc, rstd, rstm, rstp, rstcarryin, rstopmode;
   logic        cea, ceb, cec, ced, cem, cep, ceopmode, cecarryin;
   logic [17:0] a, b, d, bcin;
   logic [47:0] c, pcin;
   logic        carryin;
   logic [7:0]  opmode;

   logic [17:0] bcout, bcout_ci;
   logic [35:0] m, m_ci;
   logic [47:0] p, pcout, p_ci, pcout_ci;
   logic        carryout, carryoutf, carryout_ci, carryoutf_ci;

   int checks = 0;
   int errors = 0;

   dsp48a1 dut (
      .CLK(CLK), .RSTA(rsta), .RSTB(rstb), .RSTC(rstc), .RSTD(rstd), .RSTM(rstm),
      .RSTP(rstp), .RSTCARRYIN(rstcarryin), .RSTOPMODE(rstopmode),
      .CEA(cea), .CEB(ceb), .CEC(cec), .CED(ced), .CEM(cem), .CEP(cep),
      .CEOPMODE(ceopmode), .CECARRYIN(cecarryin),
      .A(a), .B(b), .D(d), .C(c), .BCIN(bcin), .PCIN(pcin), .CARRYIN(carryin),
      .OPMODE(opmode), .BCOUT(bcout), .M(m), .P(p), .PCOUT(pcout),
      .CARRYOUT(carryout), .CARRYOUTF(carryoutf));

   dsp48a1 #(.CARRYINSEL("CARRYIN")) dut_ci (
      .CLK(CLK), .RSTA(rsta), .RSTB(rstb), .RSTC(rstc), .RSTD(rstd), .RSTM(rstm),
      .RSTP(rstp), .RSTCARRYIN(rstcarryin), .RSTOPMODE(rstopmode),
      .CEA(cea), .CEB(ceb), .CEC(cec), .CED(ced), .CEM(cem), .CEP(cep),
      .CEOPMODE(ceopmode), .CECARRYIN(cecarryin),
      .A(a), .B(b), .D(d), .C(c), .BCIN(bcin), .PCIN(pcin), .CARRYIN(carryin),
      .OPMODE(opmode), .BCOUT(bcout_ci), .M(m_ci), .P(p_ci), .PCOUT(pcout_ci),
      .CARRYOUT(carryout_ci), .CARRYOUTF(carryoutf_ci));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic set_rst(input logic v);
      rsta = v; rstb = v; rstc = v; rstd = v;
      rstm = v; rstp = v; rstcarryin = v; rstopmode = v;
   endtask

   task automatic set_ce(input logic v);
      cea = v; ceb = v; cec = v; ced = v;
      cem = v; cep = v; ceopmode = v; cecarryin = v;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic apply(input logic [17:0] av, input logic [17:0] bv, input logic [17:0] dv,
                        input logic [47:0] cv, input logic [7:0] opv);
      a = av; b = bv; d = dv; c = cv; opmode = opv;
   endtask

   // Expected B1 for A=3,B=5,D=10 with OPMODE[4]=1: D+B when the pre-adder exists.
   function automatic logic [17:0] exp_b1_add();
      return PREADD ? 18'd15 : 18'd5;
   endfunction

   task automatic check_all_zero(input string tag);
      checks++;
      if (bcout !== 18'd0) begin $display("FAIL %s_bcout got %h want 0", tag, bcout); errors++; end
      checks++;
      if (m !== 36'd0) begin $display("FAIL %s_m got %h want 0", tag, m); errors++; end
      checks++;
      if (p !== 48'd0) begin $display("FAIL %s_p got %h want 0", tag, p); errors++; end
      checks++;
      if (pcout !== 48'd0) begin $display("FAIL %s_pcout got %h want 0", tag, pcout); errors++; end
      checks++;
      if (carryout !== 1'b0) begin $display("FAIL %s_carryout got %b want 0", tag, carryout); errors++; end
      checks++;
      if (carryoutf !== 1'b0) begin $display("FAIL %s_carryoutf got %b want 0", tag, carryoutf); errors++; end
   endtask

   task automatic test_reset();
      logic [17:0] eb;
      set_ce(1'b1);
      set_rst(1'b1);
      apply(18'd0, 18'd0, 18'd0, 48'd0, 8'h00);
      bcin = 18'd0; pcin = 48'd0; carryin = 1'b0;
      #2;
      check_all_zero("reset_init");
      step(1);
      set_rst(1'b0);
      apply(18'd3, 18'd5, 18'd10, 48'd100, 8'h1D);
      step(3);
      eb = exp_b1_add();
      checks++;
      if (bcout !== eb) begin $display("FAIL pre_reset_bcout got %h want %h", bcout, eb); errors++; end
      set_rst(1'b1);
      #1;
      check_all_zero("reset_mid");
      step(1);
      set_rst(1'b0);
   endtask

   task automatic test_add();
      logic [17:0] eb;
      logic [35:0] em;
      logic [47:0] ep;
      eb = exp_b1_add();
      em = 36'd3 * 36'(eb);
      ep = 48'd100 + 48'(em);
      apply(18'd3, 18'd5, 18'd10, 48'd100, 8'h1D);
      step(4);
      checks++;
      if (bcout !== eb) begin $display("FAIL add_bcout got %h want %h", bcout, eb); errors++; end
      checks++;
      if (m !== em) begin $display("FAIL add_m got %h want %h", m, em); errors++; end
      checks++;
      if (p !== ep) begin $display("FAIL add_p got %h want %h", p, ep); errors++; end
      checks++;
      if (pcout !== ep) begin $display("FAIL add_pcout got %h want %h", pcout, ep); errors++; end
      checks++;
      if (carryout !== 1'b0) begin $display("FAIL add_carryout got %b want 0", carryout); errors++; end
      checks++;
      if (carryoutf !== 1'b0) begin $display("FAIL add_carryoutf got %b want 0", carryoutf); errors++; end
   endtask

   task automatic test_post_sub();
      logic [35:0] em;
      logic [47:0] ep;
      em = 36'd3 * 36'(exp_b1_add());
      apply(18'd3, 18'd5, 18'd10, 48'd100, 8'hBD);
      step(4);
      ep = 48'd100 - 48'(em) - 48'd1;
      checks++;
      if (p !== ep) begin $display("FAIL sub_p got %h want %h", p, ep); errors++; end
      checks++;
      if (carryout !== 1'b0) begin $display("FAIL sub_carryout got %b want 0", carryout); errors++; end
      c = 48'd10;
      step(4);
      ep = 48'd10 - 48'(em) - 48'd1;
      checks++;
      if (p !== ep) begin $display("FAIL sub_borrow_p got %h want %h", p, ep); errors++; end
      checks++;
      if (carryout !== 1'b1) begin $display("FAIL sub_borrow_carryout got %b want 1", carryout); errors++; end
      checks++;
      if (carryoutf !== 1'b1) begin $display("FAIL sub_borrow_carryoutf got %b want 1", carryoutf); errors++; end
   endtask

   task automatic test_x_concat();
      logic [47:0] ep;
      ep = {12'd10, 18'd3, 18'd5};
      apply(18'd3, 18'd5, 18'd10, 48'd0, 8'h03);
      step(4);
      checks++;
      if (p !== ep) begin $display("FAIL xdab_p got %h want %h", p, ep); errors++; end
      checks++;
      if (carryout !== 1'b0) begin $display("FAIL xdab_carryout got %b want 0", carryout); errors++; end
   endtask

   task automatic test_pcin();
      pcin = 48'd1000;
      apply(18'd3, 18'd5, 18'd10, 48'd0, 8'h05);
      step(4);
      checks++;
      if (p !== 48'd1015) begin $display("FAIL pcin_p got %h want %h", p, 48'd1015); errors++; end
      pcin = 48'd0;
   endtask

   task automatic test_preadder();
      logic [17:0] eb;
      apply(18'd3, 18'd5, 18'd10, 48'd0, 8'h4D);
      step(4);
      checks++;
      if (bcout !== 18'd5) begin $display("FAIL pre_nosel_bcout got %h want %h", bcout, 18'd5); errors++; end
      opmode = 8'h5D;
      step(4);
      checks++;
      if (bcout !== 18'd5) begin $display("FAIL pre_sub_bcout got %h want %h", bcout, 18'd5); errors++; end
      b = 18'd12;
      step(4);
      eb = PREADD ? 18'h3FFFE : 18'd12;
      checks++;
      if (bcout !== eb) begin $display("FAIL pre_wrap_bcout got %h want %h", bcout, eb); errors++; end
   endtask

   task automatic test_accumulate();
      carryin = 1'b1;
      apply(18'd3, 18'd15, 18'd0, 48'd0, 8'h09);
      cep = 1'b0;
      step(4);
      rstp = 1'b1;
      #1;
      checks++;
      if (p !== 48'd0) begin $display("FAIL acc_clear_p got %h want 0", p); errors++; end
      checks++;
      if (p_ci !== 48'd0) begin $display("FAIL acc_clear_p_ci got %h want 0", p_ci); errors++; end
      rstp = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         cep = 1'b1;
         step(1);
         cep = 1'b0;
         checks++;
         if (p !== 48'(45 * k)) begin
            $display("FAIL acc_p_%0d got %0d want %0d", k, p, 45 * k); errors++;
         end
         checks++;
         if (p_ci !== 48'(46 * k)) begin
            $display("FAIL acc_cin_p_%0d got %0d want %0d", k, p_ci, 46 * k); errors++;
         end
      end
      step(2);
      checks++;
      if (p !== 48'd135) begin $display("FAIL acc_hold_p got %0d want 135", p); errors++; end
      cep = 1'b1;
      carryin = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_post_sub();
      test_x_concat();
      test_pcin();
      test_preadder();
      test_accumulate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
